// File: rtl/oam_dma.sv
// OAM sprite DMA: snoops CPU writes to TRIG_ADDR, halts the CPU, then copies a
// 256-byte page to OAMDATA_ADDR as 256 read/write bus cycle pairs.
module oam_dma #(
   parameter logic [15:0] TRIG_ADDR    = 16'h4014,
   parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
   input  logic        i_cpu_clk,
   input  logic        i_cpu_rstn,
   input  logic [15:0] i_bus_addr,
   input  logic        i_bus_wn,
   input  logic [7:0]  i_bus_wdata,
   output logic        o_cpu_rdy,
   output logic        o_dma_active,
   output logic [15:0] o_dma_addr,
   output logic        o_dma_wn,
   output logic [7:0]  o_dma_wdata,
   input  logic [7:0]  i_dma_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  data_q, data_d;
   logic        odd_q, odd_d;
   logic        rdy_q, rdy_d;
   logic        active_q, active_d;
   logic [15:0] addr_q, addr_d;
   logic        wn_q, wn_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        trig_s;

   assign trig_s = (i_bus_addr == TRIG_ADDR) && (i_bus_wn == 1'b0);

   // Next-state logic; bus outputs are decoded from the next state so the flops present them in that state's cycle
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      odd_d   = ~odd_q;
      case (state_q)
         ST_IDLE: begin
            if (trig_s) begin
               state_d = ST_HALT;
               page_d  = i_bus_wdata;
               cnt_d   = 8'h00;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            if (odd_q) begin
               state_d = ST_ALIGN;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_ALIGN: state_d = ST_READ;
         ST_READ: begin
            data_d  = i_dma_rdata;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            cnt_d = cnt_q + 8'h01;
            if (cnt_q == 8'hFF) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      rdy_d    = (state_d == ST_IDLE);
      active_d = (state_d == ST_READ) || (state_d == ST_WRITE);
      case (state_d)
         ST_READ: begin
            addr_d  = {page_d, cnt_d};
            wn_d    = 1'b1;
            wdata_d = 8'h00;
         end
         ST_WRITE: begin
            addr_d  = OAMDATA_ADDR;
            wn_d    = 1'b0;
            wdata_d = data_d;
         end
         default: begin
            addr_d  = 16'h0000;
            wn_d    = 1'b1;
            wdata_d = 8'h00;
         end
      endcase
   end

   // State, datapath and registered bus outputs; reset aborts any transfer at once
   always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
      if (!i_cpu_rstn) begin
         state_q  <= ST_IDLE;
         page_q   <= 8'h00;
         cnt_q    <= 8'h00;
         data_q   <= 8'h00;
         odd_q    <= 1'b0;
         rdy_q    <= 1'b1;
         active_q <= 1'b0;
         addr_q   <= 16'h0000;
         wn_q     <= 1'b1;
         wdata_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         odd_q    <= odd_d;
         rdy_q    <= rdy_d;
         active_q <= active_d;
         addr_q   <= addr_d;
         wn_q     <= wn_d;
         wdata_q  <= wdata_d;
      end
   end

   assign o_cpu_rdy    = rdy_q;
   assign o_dma_active = active_q;
   assign o_dma_addr   = addr_q;
   assign o_dma_wn     = wn_q;
   assign o_dma_wdata  = wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: memory model, read/write scoreboard,
// table of single DMAs plus re-trigger, mid-DMA reset and back-to-back cases.
module tb_oam_dma;

   localparam logic [15:0] TRIG  = 16'h4014;
   localparam logic [15:0] OAMD  = 16'h2004;

   logic        clk = 1'b0;
   logic        rstn;
   logic [15:0] bus_addr;
   logic        bus_wn;
   logic [7:0]  bus_wdata;
   logic        cpu_rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_wn;
   logic [7:0]  dma_wdata;
   logic [7:0]  dma_rdata;

   logic [7:0]  mem [0:65535];
   logic        odd_m;

   typedef struct packed {
      logic [15:0] raddr;
      logic [7:0]  data;
   } sb_t;
   sb_t sb [$];

   typedef struct {
      logic [7:0] page;
      logic       par;
      int         exp_len;
   } vec_t;
   vec_t vecs [5];

   int checks = 0;
   int errors = 0;
   int low_cnt = 0;
   int writes = 0;
   int total = 0;
   int exp_halt = 0;

   oam_dma dut (
      .i_cpu_clk   (clk),
      .i_cpu_rstn  (rstn),
      .i_bus_addr  (bus_addr),
      .i_bus_wn    (bus_wn),
      .i_bus_wdata (bus_wdata),
      .o_cpu_rdy   (cpu_rdy),
      .o_dma_active(dma_active),
      .o_dma_addr  (dma_addr),
      .o_dma_wn    (dma_wn),
      .o_dma_wdata (dma_wdata),
      .i_dma_rdata (dma_rdata)
   );

   always #5 clk = ~clk;

   assign dma_rdata = mem[dma_addr];

   // Reference copy of the DMA's clock parity flop
   always @(posedge clk or negedge rstn) begin
      if (!rstn) odd_m <= 1'b0;
      else       odd_m <= ~odd_m;
   end

   function automatic logic [7:0] pat(input logic [15:0] a);
      if (a[15:8] == 8'hFF) return a[7:0];
      else                  return a[7:0] ^ (a[15:8] + 8'h5A);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"},    {31'd0, cpu_rdy},    32'd1);
      chk({tag, "_active"}, {31'd0, dma_active}, 32'd0);
      chk({tag, "_wn"},     {31'd0, dma_wn},     32'd1);
      chk({tag, "_addr"},   {16'd0, dma_addr},   32'd0);
      chk({tag, "_wdata"},  {24'd0, dma_wdata},  32'd0);
   endtask

   // Start a DMA; with align set, wait until HALT will see r_odd == par
   task automatic trigger(input logic [7:0] page, input logic align, input logic par);
      if (align) begin
         @(negedge clk);
         if (odd_m == par) @(negedge clk);
      end
      exp_halt  = odd_m ? 513 : 514;
      bus_addr  = TRIG;
      bus_wn    = 1'b0;
      bus_wdata = page;
      low_cnt   = 0;
      writes    = 0;
      for (int i = 0; i < 256; i++) begin
         sb_t e;
         e.raddr = {page, i[7:0]};
         e.data  = pat(e.raddr);
         sb.push_back(e);
      end
      @(negedge clk);
      bus_wn   = 1'b1;
      bus_addr = 16'h0000;
      chk("rdy_low_after_trigger", {31'd0, cpu_rdy}, 32'd0);
   endtask

   task automatic wait_done(input int exp_len);
      int guard = 0;
      while (cpu_rdy !== 1'b1 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      chk("done_timeout", {31'd0, guard < 2000}, 32'd1);
      chk("halt_length", low_cnt, exp_len);
      chk("write_count", writes, 32'd256);
      chk("sb_empty", sb.size(), 32'd0);
      chk("idle_active", {31'd0, dma_active}, 32'd0);
   endtask

   // Bus monitor: read address order, OAM write data, halt-cycle count
   initial begin
      forever begin
         @(negedge clk);
         if (!cpu_rdy) low_cnt++;
         if (dma_active) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_dma_cycle: got addr %h expected no access", dma_addr);
            end else if (dma_wn) begin
               chk("read_addr", {16'd0, dma_addr}, {16'd0, sb[0].raddr});
            end else begin
               chk("write_addr", {16'd0, dma_addr}, {16'd0, OAMD});
               chk("write_data", {24'd0, dma_wdata}, {24'd0, sb[0].data});
               void'(sb.pop_front());
               writes++;
               total++;
            end
         end else begin
            chk("idle_bus", {7'd0, dma_addr, dma_wn, dma_wdata}, {7'd0, 16'h0000, 1'b1, 8'h00});
         end
      end
   end

   initial begin
      int guard;
      for (int a = 0; a < 65536; a++) begin
         logic [15:0] av;
         av = a[15:0];
         mem[a] = pat(av);
      end
      vecs[0] = '{8'h02, 1'b0, 513};
      vecs[1] = '{8'h02, 1'b1, 514};
      vecs[2] = '{8'hFF, 1'b0, 513};
      vecs[3] = '{8'h20, 1'b1, 514};
      vecs[4] = '{8'h00, 1'b1, 514};

      rstn      = 1'b0;
      bus_addr  = 16'h0000;
      bus_wn    = 1'b1;
      bus_wdata = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rstn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         trigger(vecs[i].page, 1'b1, vecs[i].par);
         wait_done(vecs[i].exp_len);
      end

      // Re-trigger with page 05 while the bus is owned by the DMA
      trigger(8'h02, 1'b1, 1'b0);
      guard = 0;
      while (dma_active !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("active_timeout", {31'd0, guard < 20}, 32'd1);
      repeat (20) @(negedge clk);
      bus_addr  = TRIG;
      bus_wn    = 1'b0;
      bus_wdata = 8'h05;
      @(negedge clk);
      bus_wn   = 1'b1;
      bus_addr = 16'h0000;
      wait_done(513);

      // Reset during the 100th OAM write, then a clean restart on page 03
      trigger(8'h07, 1'b1, 1'b0);
      guard = 0;
      while (writes != 100 && guard < 3000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      chk("w100_timeout", {31'd0, guard < 3000}, 32'd1);
      chk("w100_is_write", {31'd0, dma_wn}, 32'd0);
      rstn = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      sb.delete();
      @(negedge clk);
      rstn = 1'b1;
      trigger(8'h03, 1'b1, 1'b1);
      wait_done(514);

      // Back-to-back: second trigger on the first ready cycle
      total = 0;
      trigger(8'h02, 1'b1, 1'b0);
      wait_done(513);
      trigger(8'h03, 1'b0, 1'b0);
      wait_done(exp_halt);
      chk("b2b_total_writes", total, 32'd512);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
Parameters:
REQ-001 SHALL have parameter TRIG_ADDR, default 16'h4014, the CPU write address that starts a DMA.
REQ-002 SHALL have parameter OAMDATA_ADDR, default 16'h2004, the destination address driven on DMA write cycles.

Ports:
REQ-003 i_cpu_clk  input  1  CPU clock.
REQ-004 i_cpu_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_bus_addr  input  16  CPU bus address, snooped.
REQ-006 i_bus_wn  input  1  CPU bus write strobe, active-low (0 = write).
REQ-007 i_bus_wdata  input  8  CPU bus write data.
REQ-008 o_cpu_rdy  output  1  CPU ready; 0 halts the CPU.
REQ-009 o_dma_active  output  1  1 = DMA owns the bus; the system bus mux selects o_dma_* over the CPU.
REQ-010 o_dma_addr  output  16  DMA bus address.
REQ-011 o_dma_wn  output  1  DMA write strobe, active-low.
REQ-012 o_dma_wdata  output  8  DMA write data.
REQ-013 i_dma_rdata  input  8  bus read data returned to the DMA.

Function
REQ-014 Trigger: TRIG_ADDR is written when i_bus_addr==TRIG_ADDR and i_bus_wn==0 at a posedge while state is IDLE.
- On trigger, latch r_page <= i_bus_wdata and clear r_cnt (8 bits) to 0.
- A TRIG_ADDR write while not IDLE is ignored and does not change r_page.

REQ-015 Parity: r_odd resets to 0 and toggles on every clock.

REQ-016 States are IDLE, HALT, ALIGN, READ, WRITE. Transitions:
- IDLE -> HALT on trigger.
- HALT -> ALIGN if r_odd==1 during HALT; otherwise HALT -> READ.
- ALIGN -> READ.
- READ -> WRITE.
- WRITE -> READ if r_cnt != 8'hFF.
- WRITE -> IDLE if r_cnt == 8'hFF.

REQ-017 o_cpu_rdy SHALL be 0 in every state except IDLE; it is a registered state decode, so it goes low the cycle after the trigger write.

REQ-018 o_dma_active SHALL be 1 only in READ and WRITE.

REQ-019 READ cycle:
- o_dma_addr = {r_page, r_cnt}, o_dma_wn = 1.
- i_dma_rdata is captured into r_data at the end of the cycle.

REQ-020 WRITE cycle:
- o_dma_addr = OAMDATA_ADDR, o_dma_wn = 0, o_dma_wdata = r_data.
- r_cnt increments modulo 256 at the end of the cycle.

REQ-021 When idle or in HALT/ALIGN: o_dma_addr = 16'h0000, o_dma_wn = 1, o_dma_wdata = 8'h00.

REQ-022 Exactly 256 read/write pairs per DMA, from source {page,00} through {page,FF}, in ascending order.
- r_cnt wraps 8'hFF -> 8'h00 on the final write and never carries into r_page.

REQ-023 Halt length (o_cpu_rdy low):
- 513 cycles when HALT has r_odd==0.
- 514 cycles when HALT has r_odd==1.

REQ-024 Page 8'h20 (source inside PPU register space) SHALL be transferred identically; no special-casing of the source page.

REQ-025 A CPU-side bus write that coincides with a DMA cycle is ignored. The CPU is halted, so this only matters for the trigger cycle itself, which is handled by REQ-014.

Reset
REQ-026 Asynchronous reset values:
- State IDLE; r_page, r_cnt, r_data = 0; r_odd = 0.
- o_cpu_rdy = 1, o_dma_active = 0, o_dma_wn = 1, o_dma_addr = 0, o_dma_wdata = 0.

REQ-027 Reset asserted mid-DMA aborts immediately:
- All outputs return to reset values.
- No further OAM writes occur.
- After release, the next trigger restarts from r_cnt = 0.

Verification
REQ-028 Even-parity trigger: write 8'h02 to $4014 with r_odd==0 in the following HALT cycle ->
- o_cpu_rdy low for 513 cycles.
- First READ addr $0200; 256 writes to $2004 carrying mem[$0200..$02FF] in order.

REQ-029 Odd-parity trigger: same stimulus with r_odd==1 in HALT -> one ALIGN cycle inserted; o_cpu_rdy low for 514 cycles; data identical to REQ-028.

REQ-030 Page 8'hFF with source pattern data = low address byte ->
- OAM receives 00..FF.
- Last READ addr $FFFF; no access to $0000 afterwards.
- o_cpu_rdy returns to 1 the cycle after the final WRITE.

REQ-031 Re-trigger during DMA: write 8'h05 to $4014 while o_dma_active==1 -> ignored; transfer continues from the original page; exactly 256 writes total.

REQ-032 Reset at the 100th WRITE ->
- Outputs at reset values in the same cycle.
- After release, a trigger with 8'h03 produces a full 256-byte transfer starting at $0300.

REQ-033 Back-to-back DMAs: trigger $4014 with 8'h02, then with 8'h03 issued on the first cycle o_cpu_rdy==1 -> second DMA starts normally; total 512 OAM writes, each page's data in order.
